// File: rtl/m_dram_req_bridge.sv
// m_dram_req_bridge: valid/ready front end for the MIG 7-series app interface.
// Read returns are buffered in a FIFO sized by a credit count of outstanding reads.
module m_dram_req_bridge #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128,
    parameter int MASK_WIDTH = 16,
    parameter int RD_DEPTH   = 16
) (
    input  logic                       w_clk,
    input  logic                       w_rst_n,
    input  logic                       i_calib_done,
    input  logic                       i_req_valid,
    output logic                       o_req_ready,
    input  logic                       i_req_we,
    input  logic [ADDR_WIDTH-1:0]      i_req_addr,
    input  logic [DATA_WIDTH-1:0]      i_req_wdata,
    input  logic [MASK_WIDTH-1:0]      i_req_mask,
    output logic                       o_rd_valid,
    output logic [DATA_WIDTH-1:0]      o_rd_data,
    input  logic                       i_rd_ready,
    output logic [ADDR_WIDTH-1:0]      o_app_addr,
    output logic [2:0]                 o_app_cmd,
    output logic                       o_app_en,
    input  logic                       i_app_rdy,
    output logic [DATA_WIDTH-1:0]      o_app_wdf_data,
    output logic [MASK_WIDTH-1:0]      o_app_wdf_mask,
    output logic                       o_app_wdf_wren,
    input  logic                       i_app_wdf_rdy,
    input  logic [DATA_WIDTH-1:0]      i_app_rd_data,
    input  logic                       i_app_rd_valid,
    output logic [$clog2(RD_DEPTH):0]  o_credits,
    output logic                       o_err
);
    localparam int AW = $clog2(RD_DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic {IDLE, ISSUE} state_t;
    state_t state, state_nx;
    logic [CW-1:0] inflight, wr_ptr, rd_ptr, count;
    logic [DATA_WIDTH-1:0] mem [RD_DEPTH];
    logic accept, rd_hs, done, full, pop, push, drop, unused_addr;
    assign unused_addr = ^i_req_addr[2:0];
    assign o_req_ready = state == IDLE && i_calib_done && o_credits < CW'(RD_DEPTH);
    assign accept      = i_req_valid & o_req_ready;
    assign rd_hs       = o_app_en & i_app_rdy & (o_app_cmd == 3'b001);
    assign done        = (!o_app_en || i_app_rdy) && (!o_app_wdf_wren || i_app_wdf_rdy);
    assign count       = wr_ptr - rd_ptr;
    assign full        = count == CW'(RD_DEPTH);
    assign o_rd_valid  = count != '0;
    assign pop         = o_rd_valid & i_rd_ready;
    // Returns with nothing outstanding, or into a full FIFO that is not draining, are lost.
    assign drop        = i_app_rd_valid && (inflight == '0 || (full && !pop));
    assign push        = i_app_rd_valid & !drop;
    assign o_rd_data   = o_rd_valid ? mem[rd_ptr[AW-1:0]] : '0;
    always_comb begin
        state_nx = state;
        state_nx = state == IDLE ? (accept ? ISSUE : IDLE) : (done ? IDLE : ISSUE);
    end
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            o_app_addr     <= '0;
            o_app_cmd      <= 3'b001;
            o_app_wdf_data <= '0;
            o_app_wdf_mask <= '0;
            o_app_en       <= 1'b0;
            o_app_wdf_wren <= 1'b0;
            o_credits      <= '0;
            inflight       <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            o_err          <= 1'b0;
        end else begin
            if (accept) begin
                o_app_addr     <= {i_req_addr[ADDR_WIDTH-1:3], 3'b000};
                o_app_cmd      <= i_req_we ? 3'b000 : 3'b001;
                o_app_wdf_data <= i_req_wdata;
                o_app_wdf_mask <= i_req_mask;
                o_app_en       <= 1'b1;
                o_app_wdf_wren <= i_req_we;
            end else begin
                if (i_app_rdy) o_app_en <= 1'b0;
                if (i_app_wdf_rdy) o_app_wdf_wren <= 1'b0;
            end
            o_credits <= o_credits + CW'(rd_hs) - CW'(pop);
            inflight  <= inflight + CW'(rd_hs) - CW'(i_app_rd_valid && inflight != '0);
            wr_ptr    <= wr_ptr + CW'(push);
            rd_ptr    <= rd_ptr + CW'(pop);
            if (drop) o_err <= 1'b1;
        end
    end
    always_ff @(posedge w_clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= i_app_rd_data;
    end
endmodule

// File: tb/tb_m_dram_req_bridge.sv
// tb_m_dram_req_bridge: table-driven write handshakes plus scoreboarded read returns.
module tb_m_dram_req_bridge;
    logic         w_clk = 0, w_rst_n = 0;
    logic         i_calib_done = 0, i_req_valid = 0, i_req_we = 0, i_rd_ready = 0;
    logic [27:0]  i_req_addr = '0;
    logic [127:0] i_req_wdata = '0, i_app_rd_data = '0;
    logic [15:0]  i_req_mask = '0;
    logic         i_app_rdy = 0, i_app_wdf_rdy = 0, i_app_rd_valid = 0;
    logic         o_req_ready, o_rd_valid, o_app_en, o_app_wdf_wren, o_err;
    logic [127:0] o_rd_data, o_app_wdf_data;
    logic [27:0]  o_app_addr;
    logic [2:0]   o_app_cmd;
    logic [15:0]  o_app_wdf_mask;
    logic [4:0]   o_credits;
    int checks = 0, errors = 0;

    typedef struct {
        logic [27:0]  addr;
        logic [127:0] data;
        logic [15:0]  mask;
        int           app_dly;
        int           wdf_dly;
        logic [27:0]  exp_addr;
        int           exp_en;
        int           exp_wren;
    } wvec_t;
    typedef struct {
        logic [27:0]  addr;
        logic [127:0] data;
        logic [15:0]  mask;
    } req_t;
    wvec_t        tbl [5];
    req_t         req_q [$];
    logic [127:0] rd_q [$];

    m_dram_req_bridge dut (
        .w_clk(w_clk), .w_rst_n(w_rst_n), .i_calib_done(i_calib_done),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_mask(i_req_mask),
        .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data), .i_rd_ready(i_rd_ready),
        .o_app_addr(o_app_addr), .o_app_cmd(o_app_cmd), .o_app_en(o_app_en),
        .i_app_rdy(i_app_rdy), .o_app_wdf_data(o_app_wdf_data), .o_app_wdf_mask(o_app_wdf_mask),
        .o_app_wdf_wren(o_app_wdf_wren), .i_app_wdf_rdy(i_app_wdf_rdy),
        .i_app_rd_data(i_app_rd_data), .i_app_rd_valid(i_app_rd_valid),
        .o_credits(o_credits), .o_err(o_err)
    );

    always #5 w_clk = ~w_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge w_clk) begin
        if (o_rd_valid && i_rd_ready) begin
            if (rd_q.size() == 0) chk("rd_unexpected", o_rd_data, 128'hx);
            else chk("rd_data", o_rd_data, rd_q.pop_front());
        end
    end

    task automatic step();
        @(posedge w_clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!o_req_ready && n < 100) begin
            step();
            n++;
        end
        if (!o_req_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic send(input logic we, input logic [27:0] a, input logic [127:0] d, input logic [15:0] m);
        wait_ready();
        i_req_valid = 1; i_req_we = we; i_req_addr = a; i_req_wdata = d; i_req_mask = m;
        step();
        i_req_valid = 0;
    endtask

    task automatic issue_read(input logic [27:0] a);
        i_app_rdy = 1;
        send(0, a, '0, '0);
        step();
    endtask

    task automatic mig_return(input logic [127:0] d, input logic track);
        i_app_rd_valid = 1; i_app_rd_data = d;
        if (track) rd_q.push_back(d);
        step();
        i_app_rd_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        i_rd_ready = 1;
        while (rd_q.size() > 0 && n < 40) begin
            step();
            n++;
        end
        i_rd_ready = 0;
        chk("drain_left", 128'(rd_q.size()), 0);
    endtask

    initial begin
        int k, en_n, wren_n;
        logic stable, rdy_low;
        req_t e;
        tbl[0] = '{28'h0000013, 128'h1, 16'h0000, 0, 3, 28'h0000010, 1, 4};
        tbl[1] = '{28'h0000105, 128'hCAFE_F00D, 16'h00F0, 5, 0, 28'h0000100, 6, 1};
        tbl[2] = '{28'hFFFFFFF, {4{32'hA5A5_5A5A}}, 16'hFFFF, 0, 0, 28'hFFFFFF8, 1, 1};
        tbl[3] = '{28'h0ABCDE9, 128'h1234, 16'h8001, 2, 2, 28'h0ABCDE8, 3, 3};
        tbl[4] = '{28'h0000047, 128'h77, 16'h0002, 1, 4, 28'h0000040, 2, 5};

        step(); step();
        chk("rst_app_en", o_app_en, 0);
        chk("rst_wren", o_app_wdf_wren, 0);
        chk("rst_cmd", o_app_cmd, 3'b001);
        chk("rst_rd_valid", o_rd_valid, 0);
        chk("rst_credits", o_credits, 0);
        chk("rst_err", o_err, 0);
        chk("rst_ready", o_req_ready, 0);
        w_rst_n = 1;
        step();

        i_req_valid = 1; i_req_we = 1; i_req_addr = 28'h40; i_req_wdata = 128'h5; i_app_rdy = 1; i_app_wdf_rdy = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("nocal_ready", o_req_ready, 0);
            chk("nocal_en", o_app_en, 0);
        end
        i_calib_done = 1;
        #1 chk("cal_ready", o_req_ready, 1);
        step();
        i_req_valid = 0;
        chk("cal_en", o_app_en, 1);
        chk("cal_wren", o_app_wdf_wren, 1);
        step();
        chk("cal_done_en", o_app_en, 0);
        chk("cal_done_ready", o_req_ready, 1);

        foreach (tbl[i]) begin
            i_app_rdy = 0; i_app_wdf_rdy = 0;
            send(1, tbl[i].addr, tbl[i].data, tbl[i].mask);
            req_q.push_back('{tbl[i].exp_addr, tbl[i].data, tbl[i].mask});
            e = req_q.pop_front();
            en_n = 0; wren_n = 0; stable = 1; rdy_low = 1; k = 0;
            while ((o_app_en || o_app_wdf_wren) && k < 50) begin
                i_app_rdy = k >= tbl[i].app_dly;
                i_app_wdf_rdy = k >= tbl[i].wdf_dly;
                if (o_app_en) en_n++;
                if (o_app_wdf_wren) wren_n++;
                if (o_app_addr !== e.addr || o_app_wdf_data !== e.data || o_app_wdf_mask !== e.mask || o_app_cmd !== 3'b000) stable = 0;
                if (o_req_ready) rdy_low = 0;
                step();
                k++;
            end
            chk($sformatf("w%0d_en_cycles", i), en_n, tbl[i].exp_en);
            chk($sformatf("w%0d_wren_cycles", i), wren_n, tbl[i].exp_wren);
            chk($sformatf("w%0d_stable", i), stable, 1);
            chk($sformatf("w%0d_busy", i), rdy_low, 1);
            chk($sformatf("w%0d_ready_after", i), o_req_ready, 1);
        end
        i_app_rdy = 0; i_app_wdf_rdy = 0;

        for (int i = 0; i < 16; i++) issue_read(28'(i * 8));
        chk("t4_credits_full", o_credits, 16);
        chk("t4_ready_low", o_req_ready, 0);
        chk("t4_rd_valid_empty", o_rd_valid, 0);
        mig_return(128'd0, 1);
        chk("t4_rd_valid_rise", o_rd_valid, 1);
        for (int i = 1; i < 16; i++) mig_return(128'(i), 1);
        chk("t4_credits_held", o_credits, 16);
        chk("t4_err", o_err, 0);
        drain();
        chk("t4_credits_zero", o_credits, 0);
        chk("t4_rd_valid_zero", o_rd_valid, 0);

        for (int i = 0; i < 16; i++) issue_read(28'h100 + 28'(i * 8));
        for (int i = 0; i < 16; i++) mig_return(128'(100 + i), 1);
        chk("t5_credits_full", o_credits, 16);
        chk("t5_err_full", o_err, 0);
        i_rd_ready = 1;
        step();
        i_rd_ready = 0;
        chk("t5_credits_pop", o_credits, 15);
        chk("t5_ready_back", o_req_ready, 1);
        issue_read(28'h200);
        chk("t5_credits_refill", o_credits, 16);
        i_rd_ready = 1;
        mig_return(128'd116, 1);
        i_rd_ready = 0;
        chk("t5_credits_pushpop", o_credits, 15);
        chk("t5_err_pushpop", o_err, 0);
        drain();
        chk("t5_credits_zero", o_credits, 0);
        chk("t5_err_clean", o_err, 0);
        mig_return(128'hDEAD, 0);
        chk("t5_err_orphan", o_err, 1);
        chk("t5_orphan_dropped", o_rd_valid, 0);

        issue_read(28'h300);
        i_app_rdy = 0; i_app_wdf_rdy = 0;
        send(1, 28'h400, 128'hBEEF, 16'h3);
        chk("t6_en_before", o_app_en, 1);
        w_rst_n = 0;
        #1;
        chk("t6_async_en", o_app_en, 0);
        chk("t6_async_wren", o_app_wdf_wren, 0);
        chk("t6_async_cmd", o_app_cmd, 3'b001);
        chk("t6_async_addr", o_app_addr, 0);
        chk("t6_async_credits", o_credits, 0);
        chk("t6_async_err", o_err, 0);
        step(); step();
        w_rst_n = 1;
        step();
        chk("t6_idle_ready", o_req_ready, 1);
        chk("t6_fifo_empty", o_rd_valid, 0);
        chk("t6_en_idle", o_app_en, 0);
        mig_return(128'hBEEF, 0);
        chk("t6_stale_err", o_err, 1);
        chk("t6_stale_dropped", o_rd_valid, 0);
        chk("sb_empty", 128'(rd_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
